// File: rtl/pc_sched_pkg.sv
// Shared types and helpers for the multi-program PC scheduler.
// Branch encodings, the OS slot id and the round-robin successor.
package pc_sched_pkg;

    typedef enum logic [2:0] {
        BR_SEQ = 3'b000,
        BR_JMP = 3'b001,
        BR_BEQ = 3'b010,
        BR_JR  = 3'b011,
        BR_BNE = 3'b100,
        BR_BLT = 3'b101,
        BR_BLE = 3'b110
    } branch_op_e;

    localparam int OS_PROG = 0;

    // Successor of id among user programs 1..n-1; the OS slot is never chosen.
    function automatic int next_rr(input int id, input int n);
        if (id + 1 >= n) return 1;
        return id + 1;
    endfunction

endpackage

// File: rtl/pc_ctx_table.sv
// Per-program saved-PC register file.
// One synchronous write port, one combinational read port, cleared on reset.
module pc_ctx_table #(
    parameter int ADDR_W    = 32,
    parameter int NUM_PROGS = 4,
    localparam int IDW      = $clog2(NUM_PROGS)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_we,
    input  logic [IDW-1:0]    i_wr_idx,
    input  logic [ADDR_W-1:0] i_wr_data,
    input  logic [IDW-1:0]    i_rd_idx,
    output logic [ADDR_W-1:0] o_rd_data
);

    logic [ADDR_W-1:0] r_ctx [NUM_PROGS];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_PROGS; i++) r_ctx[i] <= '0;
        end else if (i_we) begin
            r_ctx[i_wr_idx] <= i_wr_data;
        end
    end

    assign o_rd_data = r_ctx[i_rd_idx];

endmodule

// File: rtl/pc_sched_unit.sv
// Program counter with quantum-preemptive multi-program scheduling.
// Optional PC_BOUNDS_CHECK_EN traps any user pc leaving its slot.
module pc_sched_unit
    import pc_sched_pkg::*;
#(
    parameter int ADDR_W        = 32,
    parameter int NUM_PROGS     = 4,
    parameter int SLOT_SIZE     = 200,
    parameter int FIRST_PREEMPT = 2,
    parameter int RESET_ADDR    = 199,
    localparam int IDW          = $clog2(NUM_PROGS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stop,
    input  logic [2:0]        branch_op,
    input  logic [ADDR_W-1:0] branch_tgt,
    input  logic [ADDR_W-1:0] branch_tgt_r,
    input  logic              zero,
    input  logic              negative,
    input  logic              load_pc,
    input  logic [ADDR_W-1:0] load_pc_addr,
    input  logic              end_program,
    input  logic              change_program,
    input  logic              set_quantum,
    input  logic [IDW-1:0]    ctx_rd_idx,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] saved_pc,
    output logic [ADDR_W-1:0] ctx_rd_pc,
    output logic [IDW-1:0]    active_prog,
    output logic [IDW-1:0]    next_prog,
`ifdef PC_BOUNDS_CHECK_EN
    output logic              bounds_fault,
`endif
    output logic              preempt
);

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_saved_pc;
    logic [ADDR_W-1:0] r_quantum;
    logic [ADDR_W-1:0] r_inst_cnt;
    logic [IDW-1:0]    r_active;
    logic [IDW-1:0]    r_next;
    logic              r_preempt;

    logic [ADDR_W-1:0] w_off;
    logic [ADDR_W-1:0] w_load_off;
    logic [ADDR_W-1:0] w_pc_inc;
    logic [ADDR_W-1:0] w_tgt_off;
    logic [ADDR_W-1:0] w_br_pc;
    logic [ADDR_W:0]   w_cnt_inc;
    logic [ADDR_W-1:0] w_chg_sum;
    logic [ADDR_W-1:0] w_chg_mod;
    logic [IDW-1:0]    w_chg_id;
    logic [IDW-1:0]    w_trap_next;
    logic [ADDR_W-1:0] w_save_val;
    logic              w_seq;
    logic              w_q_exp;
    logic              w_fault;
    logic              w_trap;
    logic              w_ctx_we;

    assign w_off      = ADDR_W'(r_active) * ADDR_W'(SLOT_SIZE);
    assign w_load_off = ADDR_W'(r_next) * ADDR_W'(SLOT_SIZE);
    assign w_pc_inc   = r_pc + 1'b1;
    assign w_tgt_off  = branch_tgt + w_off;
    assign w_seq      = (branch_op == BR_SEQ);

    always_comb begin
        w_br_pc = w_pc_inc;
        case (branch_op)
            BR_JMP:  w_br_pc = w_tgt_off;
            BR_BEQ:  if (zero) w_br_pc = w_tgt_off;
            BR_BNE:  if (!zero) w_br_pc = w_tgt_off;
            BR_BLT:  if (negative) w_br_pc = w_tgt_off;
            BR_BLE:  if (negative || zero) w_br_pc = w_tgt_off;
            BR_JR:   w_br_pc = branch_tgt_r;
            default: w_br_pc = w_pc_inc;
        endcase
    end

    // The instruction issuing this cycle counts toward the quantum.
    assign w_cnt_inc = {1'b0, r_inst_cnt} + 1'b1;
    assign w_q_exp   = (r_quantum != '0)
                     && (w_cnt_inc >= {1'b0, r_quantum})
                     && (r_active >= IDW'(FIRST_PREEMPT));

`ifdef PC_BOUNDS_CHECK_EN
    logic [ADDR_W-1:0] w_slot_end;
    logic              r_bounds_fault;
    assign w_slot_end = w_off + ADDR_W'(SLOT_SIZE - 1);
    assign w_fault    = (r_active != IDW'(OS_PROG)) && !load_pc
                     && ((w_br_pc < w_off) || (w_br_pc > w_slot_end));
    assign bounds_fault = r_bounds_fault;
`else
    assign w_fault = 1'b0;
`endif

    assign w_trap = ((end_program || change_program || w_q_exp) && w_seq)
                  || w_fault;

    assign w_chg_sum = branch_tgt_r + 1'b1;
    assign w_chg_mod = w_chg_sum % ADDR_W'(NUM_PROGS);
    assign w_chg_id  = (w_chg_mod == '0) ? IDW'(1) : IDW'(w_chg_mod);

    assign w_trap_next = (change_program && w_seq) ? w_chg_id
                       : IDW'(next_rr(int'(r_active), NUM_PROGS));

    assign w_save_val = ((end_program && w_seq) || w_fault) ? r_pc : w_pc_inc;
    assign w_ctx_we   = w_trap && !stop && !reset;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc       <= ADDR_W'(RESET_ADDR);
            r_saved_pc <= '0;
            r_quantum  <= '0;
            r_inst_cnt <= '0;
            r_active   <= IDW'(1);
            r_next     <= IDW'(1);
            r_preempt  <= 1'b0;
        end else begin
            r_preempt <= 1'b0;
            if (set_quantum) r_quantum <= branch_tgt_r;
            if (!stop) begin
                if (w_trap) begin
                    r_saved_pc <= w_save_val;
                    r_pc       <= '0;
                    r_active   <= IDW'(OS_PROG);
                    r_next     <= w_trap_next;
                    r_inst_cnt <= '0;
                    r_preempt  <= 1'b1;
                end else if (load_pc) begin
                    r_active   <= r_next;
                    r_pc       <= load_pc_addr + w_load_off;
                    r_inst_cnt <= '0;
                end else begin
                    r_pc <= w_br_pc;
                    if (r_active != IDW'(OS_PROG) && r_inst_cnt != '1)
                        r_inst_cnt <= r_inst_cnt + 1'b1;
                end
            end
        end
    end

`ifdef PC_BOUNDS_CHECK_EN
    always_ff @(posedge clock) begin
        if (reset) r_bounds_fault <= 1'b0;
        else       r_bounds_fault <= w_fault && !stop;
    end
`endif

    pc_ctx_table #(
        .ADDR_W    (ADDR_W),
        .NUM_PROGS (NUM_PROGS)
    ) u_ctx (
        .i_clk     (clock),
        .i_rst     (reset),
        .i_we      (w_ctx_we),
        .i_wr_idx  (r_active),
        .i_wr_data (w_save_val),
        .i_rd_idx  (ctx_rd_idx),
        .o_rd_data (ctx_rd_pc)
    );

    assign pc          = r_pc;
    assign saved_pc    = r_saved_pc;
    assign active_prog = r_active;
    assign next_prog   = r_next;
    assign preempt     = r_preempt;

endmodule

// File: tb/tb_pc_sched_unit.sv
// Directed bench for pc_sched_unit with hand-computed expectations.
// Targets the default build (PC_BOUNDS_CHECK_EN undefined).
module tb_pc_sched_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        stop;
    logic [2:0]  branch_op;
    logic [31:0] branch_tgt;
    logic [31:0] branch_tgt_r;
    logic        zero;
    logic        negative;
    logic        load_pc;
    logic [31:0] load_pc_addr;
    logic        end_program;
    logic        change_program;
    logic        set_quantum;
    logic [1:0]  ctx_rd_idx;
    logic [31:0] pc;
    logic [31:0] saved_pc;
    logic [31:0] ctx_rd_pc;
    logic [1:0]  active_prog;
    logic [1:0]  next_prog;
    logic        preempt;
`ifdef PC_BOUNDS_CHECK_EN
    logic        bounds_fault;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    pc_sched_unit dut (
        .clock          (clock),
        .reset          (reset),
        .stop           (stop),
        .branch_op      (branch_op),
        .branch_tgt     (branch_tgt),
        .branch_tgt_r   (branch_tgt_r),
        .zero           (zero),
        .negative       (negative),
        .load_pc        (load_pc),
        .load_pc_addr   (load_pc_addr),
        .end_program    (end_program),
        .change_program (change_program),
        .set_quantum    (set_quantum),
        .ctx_rd_idx     (ctx_rd_idx),
        .pc             (pc),
        .saved_pc       (saved_pc),
        .ctx_rd_pc      (ctx_rd_pc),
        .active_prog    (active_prog),
        .next_prog      (next_prog),
`ifdef PC_BOUNDS_CHECK_EN
        .bounds_fault   (bounds_fault),
`endif
        .preempt        (preempt)
    );

    task automatic idle();
        stop = 0; branch_op = 3'b000; branch_tgt = 0; branch_tgt_r = 0;
        zero = 0; negative = 0; load_pc = 0; load_pc_addr = 0;
        end_program = 0; change_program = 0; set_quantum = 0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        idle();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_ctx(input string tag, input logic [1:0] idx,
                           input logic [31:0] exp);
        ctx_rd_idx = idx;
        #1;
        chk(tag, ctx_rd_pc, exp);
    endtask

    initial begin
        idle();
        ctx_rd_idx = 0;
        reset = 1;
        tick();
        tick();
        chk("rst_pc", pc, 199);
        chk("rst_active", 32'(active_prog), 1);
        chk("rst_next", 32'(next_prog), 1);
        chk("rst_saved", saved_pc, 0);
        chk("rst_preempt", 32'(preempt), 0);
        chk_ctx("rst_ctx2", 2, 0);
        reset = 0;
        tick();
        chk("seq_after_rst", pc, 200);

        change_program = 1; branch_tgt_r = 1;
        tick();
        chk("chg1_pc", pc, 0);
        chk("chg1_next", 32'(next_prog), 2);
        chk("chg1_saved", saved_pc, 201);
        chk_ctx("chg1_ctx1", 1, 201);

        // quantum 3, prog 2 entered at 5
        set_quantum = 1; branch_tgt_r = 3;
        load_pc = 1; load_pc_addr = 5;
        tick();
        chk("q_load_pc", pc, 405);
        chk("q_load_active", 32'(active_prog), 2);
        chk("q_load_preempt", 32'(preempt), 0);
        tick();
        chk("q_pc406", pc, 406);
        tick();
        chk("q_pc407", pc, 407);
        tick();
        chk("q_trap_pc", pc, 0);
        chk("q_trap_saved", saved_pc, 408);
        chk("q_trap_next", 32'(next_prog), 3);
        chk("q_trap_preempt", 32'(preempt), 1);
        chk_ctx("q_trap_ctx2", 2, 408);
        tick();
        chk("q_preempt_clr", 32'(preempt), 0);
        chk("os_seq_pc", pc, 1);

        set_quantum = 1; branch_tgt_r = 0;
        tick();
        change_program = 1; branch_tgt_r = 1;
        tick();
        chk("chg2_next", 32'(next_prog), 2);
        chk("chg2_saved_os", saved_pc, 3);
        load_pc = 1; load_pc_addr = 10;
        tick();
        chk("br_start", pc, 410);
        branch_op = 3'b010; zero = 1; branch_tgt = 7;
        tick();
        chk("beq_taken", pc, 407);
        branch_op = 3'b100; zero = 1; branch_tgt = 7;
        tick();
        chk("bne_not_taken", pc, 408);
        branch_op = 3'b101; negative = 1; branch_tgt = 3;
        tick();
        chk("blt_taken", pc, 403);
        branch_op = 3'b011; branch_tgt_r = 50; branch_tgt = 99;
        tick();
        chk("jr_abs", pc, 50);
        branch_op = 3'b111; branch_tgt = 9;
        tick();
        chk("undef_op", pc, 51);
        branch_op = 3'b110; zero = 1; branch_tgt = 9;
        tick();
        chk("ble_taken", pc, 409);
        branch_op = 3'b110; branch_tgt = 2;
        tick();
        chk("ble_not_taken", pc, 410);
        branch_op = 3'b011; branch_tgt_r = 32'hFFFF_FFFF;
        tick();
        chk("jr_max", pc, 32'hFFFF_FFFF);
        tick();
        chk("pc_wrap", pc, 0);

        change_program = 1; branch_tgt_r = 2;
        tick();
        chk("chg3_next", 32'(next_prog), 3);
        load_pc = 1; load_pc_addr = 0;
        tick();
        chk("p3_pc", pc, 600);
        end_program = 1;
        tick();
        chk("end_saved", saved_pc, 600);
        chk("end_next_wrap", 32'(next_prog), 1);
        chk_ctx("end_ctx3", 3, 600);
        change_program = 1; branch_tgt_r = 3;
        tick();
        chk("chg_zero_map", 32'(next_prog), 1);
        change_program = 1; branch_tgt_r = 1;
        tick();
        chk("chg_tgt1", 32'(next_prog), 2);

        // quantum expiry during a jmp defers the trap
        set_quantum = 1; branch_tgt_r = 2;
        tick();
        load_pc = 1; load_pc_addr = 0;
        tick();
        chk("q2_pc", pc, 400);
        tick();
        chk("q2_pc401", pc, 401);
        branch_op = 3'b001; branch_tgt = 20;
        tick();
        chk("jmp_defer_pc", pc, 420);
        chk("jmp_defer_preempt", 32'(preempt), 0);
        tick();
        chk("defer_trap_pc", pc, 0);
        chk("defer_trap_saved", saved_pc, 421);
        chk("defer_trap_next", 32'(next_prog), 3);

        set_quantum = 1; branch_tgt_r = 0;
        tick();
        load_pc = 1; load_pc_addr = 4;
        tick();
        chk("stop_pre_pc", pc, 604);
        for (int i = 0; i < 5; i++) begin
            stop = 1; end_program = 1;
            if (i == 0) begin set_quantum = 1; branch_tgt_r = 2; end
            tick();
        end
        chk("stop_pc_hold", pc, 604);
        chk("stop_saved_hold", saved_pc, 421);
        chk("stop_preempt", 32'(preempt), 0);
        tick();
        chk("post_stop_pc", pc, 605);
        tick();
        chk("post_stop_trap", pc, 0);
        chk("post_stop_saved", saved_pc, 606);
        chk("post_stop_next", 32'(next_prog), 1);

        set_quantum = 1; branch_tgt_r = 0;
        tick();
        load_pc = 1; load_pc_addr = 50;
        tick();
        chk("p1_pc", pc, 250);
        branch_op = 3'b001; branch_tgt = 250;
        tick();
`ifdef PC_BOUNDS_CHECK_EN
        chk("bf_pulse", 32'(bounds_fault), 1);
        chk("bf_pc", pc, 0);
        chk_ctx("bf_ctx1", 1, 250);
`else
        chk("oob_jmp_pc", pc, 450);
        set_quantum = 1; branch_tgt_r = 1;
        tick();
        tick();
        chk("p1_no_quantum", pc, 452);
`endif

        reset = 1; end_program = 1;
        tick();
        chk("rst_trap_pc", pc, 199);
        chk("rst_trap_saved", saved_pc, 0);
        chk_ctx("rst_trap_ctx1", 1, 0);
        reset = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
